// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI master that sends {write,addr} then len data bytes to SPIMemory, LSB first.
// Define SPI_MEM_MASTER_ABORT_EN to add the abort input.
module spi_mem_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  start,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  _select,
  output logic                  sck,
  output logic                  mosi,
`ifdef SPI_MEM_MASTER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  miso
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, SETUP, CMD0, CMD1, DATA, HOLD, DONE} state_t;
  state_t state, nxt;
  logic [7:0] cnt, left;
  logic [BW-1:0] bitn;
  logic [DATA_WIDTH-1:0] sh, rs, ld_val;
  logic [ADDR_WIDTH:0] cmd;
  logic wt, stop, half_end, shifting, rise, fall, byte_end, go, to_data, ld, last_rise;
  assign half_end = cnt == 8'(CLK_DIV - 1);
  assign shifting = (state == CMD0 || state == CMD1 || state == DATA) && !wt;
  assign rise = shifting && half_end && !sck;
  assign fall = shifting && half_end && sck;
  assign byte_end = fall && bitn == BW'(DATA_WIDTH - 1);
  assign go = state == IDLE && start;
  assign last_rise = rise && bitn == BW'(DATA_WIDTH - 1) && state == DATA && !cmd[ADDR_WIDTH];
`ifdef SPI_MEM_MASTER_ABORT_EN
  logic ab;
  assign stop = ab || (abort && state == DATA);
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) ab <= 1'b0;
    else ab <= go ? 1'b0 : stop;
`else
  assign stop = 1'b0;
`endif
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? SETUP : IDLE;
      SETUP:   nxt = half_end ? CMD0 : SETUP;
      CMD0:    nxt = byte_end ? CMD1 : CMD0;
      CMD1:    nxt = byte_end ? (left == 8'd0 ? HOLD : DATA) : CMD1;
      DATA:    nxt = byte_end && (left == 8'd1 || stop) ? HOLD : DATA;
      HOLD:    nxt = half_end ? DONE : HOLD;
      default: nxt = IDLE;
    endcase
    busy = state != IDLE && state != DONE;
    _select = !busy;
    done = state == DONE;
    mosi = sh[0];
    to_data = byte_end && nxt == DATA;
    tx_ready = ((to_data && cmd[ADDR_WIDTH]) || wt) && tx_valid;
    ld = (state == SETUP && half_end) || byte_end || tx_ready;
    ld_val = state == SETUP ? cmd[DATA_WIDTH-1:0] :
             state == CMD0  ? cmd[2*DATA_WIDTH-1:DATA_WIDTH] :
             tx_ready       ? tx_data : '0;
  end
  // a stalled write parks with sck low and the divider frozen until tx_valid
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      cnt <= '0;
      left <= '0;
      bitn <= '0;
      sh <= '0;
      rs <= '0;
      cmd <= '0;
      wt <= 1'b0;
      sck <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      cnt <= (half_end || state == IDLE || wt) ? 8'd0 : cnt + 8'd1;
      cmd <= go ? {write, addr} : cmd;
      left <= go ? len : (state == DATA && byte_end) ? left - 8'd1 : left;
      bitn <= go ? '0 : fall ? bitn + BW'(1) : bitn;
      sck <= rise ? 1'b1 : fall ? 1'b0 : sck;
      sh <= ld ? ld_val : fall ? sh >> 1 : sh;
      rs <= rise ? {miso, rs[DATA_WIDTH-1:1]} : rs;
      rx_valid <= last_rise;
      rx_data <= last_rise ? {miso, rs[DATA_WIDTH-1:1]} : rx_data;
      wt <= go ? 1'b0 : (to_data && cmd[ADDR_WIDTH]) ? !tx_valid : wt && !tx_valid;
    end
endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: random and directed frames against a behavioural SPI memory slave and scoreboard.
module tb_spi_mem_master;
  localparam int CD = 2;
  localparam int LIM = 5000;
  localparam int STALL = 16 * CD + 19;
  logic clk = 0, _reset = 0, start = 0, write = 0, tx_valid = 0, miso = 0;
  logic [14:0] addr = 0;
  logic [7:0] len = 0, tx_data = 0, rx_data;
  logic tx_ready, rx_valid, busy, done, _select, sck, mosi;
`ifdef SPI_MEM_MASTER_ABORT_EN
  logic abort = 0;
`endif
  spi_mem_master #(.CLK_DIV(CD)) dut (
    .clk(clk), ._reset(_reset), .start(start), .write(write), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .done(done), ._select(_select), .sck(sck),
    .mosi(mosi),
`ifdef SPI_MEM_MASTER_ABORT_EN
    .abort(abort),
`endif
    .miso(miso));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  logic [7:0] mem [32768];
  logic [7:0] ref_mem [32768];
  logic [7:0] exp_mosi[$], exp_rx[$], txq[$], fixed[$];
  initial for (int i = 0; i < 32768; i++) begin
    mem[i] = i[7:0];
    ref_mem[i] = i[7:0];
  end
  // behavioural SPIMemory slave; also checks each received byte
  int sb;
  logic [7:0] cur;
  logic [15:0] scmd;
  logic [14:0] sa;
  always @(negedge _select) begin
    sb = 0;
    miso = 0;
  end
  always @(posedge sck) if (!_select) begin
    cur[sb % 8] = mosi;
    sb++;
    if (sb % 8 == 0) begin
      if (exp_mosi.size() == 0) chk("mosi_unexpected", 32'(cur), 32'h100);
      else chk("mosi_byte", 32'(cur), 32'(exp_mosi.pop_front()));
      if (sb == 8) scmd[7:0] = cur;
      else if (sb == 16) begin
        scmd[15:8] = cur;
        sa = scmd[14:0];
      end else begin
        if (scmd[15]) mem[sa] = cur;
        sa++;
      end
    end
  end
  always @(negedge sck) if (!_select) miso = (sb >= 16 && !scmd[15]) ? mem[sa][sb % 8] : 1'b0;
  always @(negedge clk) if (rx_valid) begin
    if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'h100);
    else chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
  end
  int npulse, bad_txr, stall_bad, stall_left = 0, stall_idx = -1, sent = 0;
  logic cur_wr = 0, acc = 0;
  always @(posedge sck) npulse++;
  always @(negedge clk) begin
    if (tx_ready && !cur_wr) bad_txr++;
    if (stall_left > 0 && stall_left <= 10 && (sck || _select)) stall_bad++;
  end
  initial forever begin
    @(negedge clk);
    if (acc) begin
      void'(txq.pop_front());
      sent++;
      if (sent == stall_idx) stall_left = STALL;
    end
    if (stall_left > 0) begin
      stall_left--;
      tx_valid = 0;
    end else begin
      tx_valid = txq.size() > 0;
      tx_data = txq.size() > 0 ? txq[0] : 8'h00;
    end
    #1 acc = tx_valid && tx_ready;
  end
  task automatic frame(input bit w, input logic [14:0] a, input int n, input bit stall,
                       input bit spam, input int abort_at);
    int eff, cyc, lat;
    logic [7:0] d;
    bit ab_done = 0;
    eff = (abort_at >= 0 && abort_at < n) ? abort_at + 1 : n;
    exp_mosi.push_back(a[7:0]);
    exp_mosi.push_back({w, a[14:8]});
    for (int i = 0; i < n; i++) begin
      d = fixed.size() > 0 ? fixed.pop_front() : 8'($urandom);
      if (w) txq.push_back(d);
      if (i < eff) begin
        exp_mosi.push_back(w ? d : 8'h00);
        if (w) ref_mem[(32'(a) + i) & 32'h7fff] = d;
        else exp_rx.push_back(ref_mem[(32'(a) + i) & 32'h7fff]);
      end
    end
    stall_idx = stall ? 2 : -1;
    sent = 0;
    cur_wr = w;
    npulse = 0;
    bad_txr = 0;
    stall_bad = 0;
    @(negedge clk);
    start = 1;
    write = w;
    addr = a;
    len = 8'(n);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 0;
    while (!done && cyc < LIM) begin
      start = spam && (cyc % 5 == 0);
`ifdef SPI_MEM_MASTER_ABORT_EN
      if (abort) abort = 0;
      else if (abort_at >= 0 && sent == abort_at + 1 && !ab_done) begin
        abort = 1;
        ab_done = 1;
      end
`endif
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 0;
`ifdef SPI_MEM_MASTER_ABORT_EN
    abort = 0;
`endif
    lat = CD * (2 + 16 * (2 + eff)) + 1 + (stall ? 20 : 0);
    chk("latency", 32'(cyc), 32'(lat));
    chk("sck_pulses", 32'(npulse), 32'(16 + 8 * eff));
    if (!w) chk("tx_ready_in_read", 32'(bad_txr), 0);
    if (stall) chk("stall_hold", 32'(stall_bad), 0);
    chk("queues_drained", 32'(exp_mosi.size() + exp_rx.size()), 0);
    txq.delete();
    stall_idx = -1;
    stall_left = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] wexp [4];
    wexp = '{8'h01, 8'h02, 8'h04, 8'h08};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({_select, sck, mosi, tx_ready, rx_valid, busy, done, rx_data}),
        32'h4000);
    _reset = 1;
    repeat (2) @(negedge clk);
    fixed = '{8'h01, 8'h02, 8'h04, 8'h08};
    frame(1, 15'h5ead, 4, 0, 1, -1);
    repeat (10) @(negedge clk);
    chk("no_second_frame", 32'({busy, _select}), 32'b01);
    for (int i = 0; i < 4; i++) chk("slave_write", 32'(mem[15'h5ead + 15'(i)]), 32'(wexp[i]));
    frame(0, 15'h5afe, 4, 0, 0, -1);
    frame(0, 15'h7ffe, 4, 0, 0, -1);
    frame(1, 15'h0100, 4, 1, 0, -1);
    frame(0, 15'h1111, 0, 0, 0, -1);
    frame(1, 15'h2222, 0, 0, 0, -1);
    exp_mosi.push_back(8'h34);
    exp_mosi.push_back(8'h12);
    @(negedge clk);
    start = 1;
    write = 0;
    addr = 15'h1234;
    len = 4;
    @(negedge clk);
    start = 0;
    repeat (80) @(negedge clk);
    _reset = 0;
    #1 chk("reset_mid_frame", 32'({_select, sck, busy, done}), 32'b1000);
    exp_mosi.delete();
    exp_rx.delete();
    @(negedge clk);
    _reset = 1;
    @(negedge clk);
`ifdef SPI_MEM_MASTER_ABORT_EN
    frame(1, 15'h0300, 4, 0, 0, 2);
    for (int i = 0; i < 3; i++)
      chk("abort_write", 32'(mem[15'h0300 + 15'(i)]), 32'(ref_mem[15'h0300 + 15'(i)]));
    chk("abort_untouched", 32'(mem[15'h0303]), 32'h03);
`endif
    for (int k = 0; k < 10; k++)
      frame(1'($urandom), 15'($urandom), int'($urandom_range(0, 5)), 0, 1'($urandom), -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
